msi_snoop_responder: RTL and testbench
======================================

// Module: msi_snoop_responder
// PURPOSE
//  Bus-side half of the MSI coherence controller. It snoops bus requests issued by
//  other caches (BUS_READ_MISS / BUS_WRITE_MISS / BUS_INVALIDATE) and holds the
//  per-line MSI state array. It sequences a writeback of dirty data when required,
//  then downgrades or invalidates the line. The CPU-side MSI FSM writes its
//  state_next results into this array through the local update port.
// PARAMETERS
//  IDX_W  3  line index width; array holds 2**IDX_W lines
// PORTS
//  clk          in   1      single clock; all state changes on posedge
//  rst          in   1      asynchronous, active-high reset
//  snoop_valid  in   1      bus request present
//  snoop_ready  out  1      request accepted when valid&ready at posedge
//  snoop_cmd    in   2      00 INVALIDATE, 01 WRITE_MISS, 10 READ_MISS, 11 reserved
//  snoop_index  in   IDX_W  line targeted by the bus request
//  wb_valid     out  1      writeback request for a MODIFIED line
//  wb_ready     in   1      memory accepts the writeback
//  wb_index     out  IDX_W  line being written back
//  resp_valid   out  1      1-cycle pulse: snoop complete
//  resp_hit     out  1      line was non-INVALID at lookup
//  resp_wb      out  1      a writeback was performed for this snoop
//  upd_valid    in   1      CPU-side FSM state write
//  upd_ready    out  1      update accepted when valid&ready at posedge
//  upd_index    in   IDX_W  line to write
//  upd_state    in   2      00 INVALID, 01 MODIFIED, 10 SHARED
//  proto_err    out  1      1-cycle pulse on any protocol violation
// BEHAVIOUR
//  Reset (async): all lines INVALID; FSM IDLE; every output 0 except snoop_ready=1
//   and upd_ready=1.
//  FSM states: IDLE, LOOKUP, WB, RESP.
//  - IDLE:   snoop_ready=1. On accept, capture cmd/index -> LOOKUP.
//  - LOOKUP: snoop_ready=0. Read the stored state S of the captured index.
//            S==MODIFIED and cmd is READ_MISS or WRITE_MISS -> WB; otherwise -> RESP.
//  - WB:     wb_valid=1 and wb_index held stable until wb_ready. The cycle
//            wb_valid&wb_ready is sampled -> RESP. No timeout.
//  - RESP:   resp_valid=1 for exactly one cycle; resp_hit and resp_wb reflect this
//            snoop. The next-state write takes effect at the same edge -> IDLE.
//  Next-state table (S -> new state):
//  - READ_MISS:  M->S (after wb), S->S, I->I.
//  - WRITE_MISS: M->I (after wb), S->I, I->I.
//  - INVALIDATE: S->I, I->I. M -> unchanged, plus proto_err (an owner never
//    sees an INVALIDATE).
//  - cmd 11: state unchanged, proto_err in RESP, resp_hit still reported.
//  Latency: accept at edge t; resp_valid is high in cycle t+2 without writeback,
//   and t+3+N with writeback, where N = wb_ready wait cycles.
//  Update port: upd_ready=0 only when FSM!=IDLE and upd_index==captured index.
//   Otherwise the update is written at the accepting edge.
//  - Same-edge snoop accept and update to the same index: the update is written
//    and LOOKUP sees the updated value.
//  - upd_state==11: the write is dropped; proto_err pulses for 1 cycle.
//  No back-to-back accept: the earliest next accept is the cycle after RESP.
//  Reset mid-operation: abort immediately; wb_valid and resp_valid drop; the
//   array clears to INVALID.
// TESTING
//  1. upd idx3<=M; READ_MISS idx3, wb_ready=1 -> wb_valid idx3 1 cycle;
//     resp_hit=1, resp_wb=1; idx3==S.
//  2. upd idx5<=S; WRITE_MISS idx5 -> resp at t+2, resp_hit=1, resp_wb=0;
//     idx5==I; no wb_valid.
//  3. idx2=M; WRITE_MISS idx2 with wb_ready held low 4 cycles -> wb_valid
//     stable 5 cycles; upd idx2 stalled (upd_ready=0); idx2==I afterwards.
//  4. idx1=M; INVALIDATE idx1 -> proto_err pulse, idx1 stays M; cmd=11 ->
//     proto_err pulse; upd_state=11 -> proto_err pulse, write dropped.
//  5. Same edge: snoop READ_MISS idx4 + upd idx4<=M -> writeback occurs,
//     idx4==S; an upd to idx6 during WB is accepted immediately.
//  6. Assert rst during WB -> wb_valid=0 asynchronously; all lines I;
//     snoop_ready=1 after release.

Source files
------------

// File: rtl/msi_snoop_responder.sv
// Bus-side MSI snoop responder: holds the per-line MSI state array and answers
// bus snoops, with a writeback of MODIFIED data before a downgrade or invalidation.
module msi_snoop_responder #(
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snoop_valid,
    output logic             snoop_ready,
    input  logic [1:0]       snoop_cmd,
    input  logic [IDX_W-1:0] snoop_index,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [IDX_W-1:0] wb_index,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_wb,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_index,
    input  logic [1:0]       upd_state,
    output logic             proto_err
);

    localparam int unsigned Lines = 1 << IDX_W;

    localparam logic [1:0] LineI = 2'b00;
    localparam logic [1:0] LineM = 2'b01;
    localparam logic [1:0] LineS = 2'b10;

    localparam logic [1:0] CmdInv = 2'b00;
    localparam logic [1:0] CmdWm  = 2'b01;
    localparam logic [1:0] CmdRm  = 2'b10;

    typedef enum logic [1:0] {StIdle, StLookup, StWb, StResp} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cmd_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       mem_q [Lines];
    logic [1:0]       mem_d [Lines];
    logic             upd_err_q;

    logic [1:0] cur_state;
    logic [1:0] line_new;
    logic       needs_wb;
    logic       snoop_acc;
    logic       upd_acc;

    // The captured line cannot change while busy: updates to it are stalled.
    assign cur_state = mem_q[idx_q];
    assign needs_wb  = (cur_state == LineM) && ((cmd_q == CmdRm) || (cmd_q == CmdWm));
    assign snoop_acc = snoop_valid && snoop_ready;
    assign upd_acc   = upd_valid && upd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (snoop_acc) state_d = StLookup;
            StLookup: state_d = needs_wb ? StWb : StResp;
            StWb:     if (wb_ready) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        snoop_ready = 1'b0;
        wb_valid    = 1'b0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        resp_wb     = 1'b0;
        proto_err   = upd_err_q;
        wb_index    = idx_q;
        upd_ready   = !((state_q != StIdle) && (upd_index == idx_q));
        case (state_q)
            StIdle: snoop_ready = 1'b1;
            StWb:   wb_valid = 1'b1;
            StResp: begin
                resp_valid = 1'b1;
                resp_hit   = (cur_state != LineI);
                resp_wb    = needs_wb;
                if ((cmd_q == 2'b11) || ((cmd_q == CmdInv) && (cur_state == LineM))) begin
                    proto_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (cmd_q)
            CmdRm:   line_new = (cur_state == LineM) ? LineS : cur_state;
            CmdWm:   line_new = LineI;
            CmdInv:  line_new = (cur_state == LineM) ? LineM : LineI;
            default: line_new = cur_state;
        endcase
    end

    // Update lands first so a same-edge snoop accept looks up the new value.
    always_comb begin
        mem_d = mem_q;
        if (upd_acc && (upd_state != 2'b11)) begin
            mem_d[upd_index] = upd_state;
        end
        if (state_q == StResp) begin
            mem_d[idx_q] = line_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q     <= '{default: LineI};
            cmd_q     <= 2'b00;
            idx_q     <= '0;
            upd_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            upd_err_q <= upd_acc && (upd_state == 2'b11);
            if (snoop_acc) begin
                cmd_q <= snoop_cmd;
                idx_q <= snoop_index;
            end
        end
    end

endmodule

// File: tb/tb_msi_snoop_responder.sv
// Directed bench for msi_snoop_responder; line states are observed through
// READ_MISS probes (hit/writeback flags) rather than internal peeks.
module tb_msi_snoop_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       snoop_valid = 1'b0;
    logic       snoop_ready;
    logic [1:0] snoop_cmd = 2'b00;
    logic [2:0] snoop_index = '0;
    logic       wb_valid;
    logic       wb_ready = 1'b0;
    logic [2:0] wb_index;
    logic       resp_valid;
    logic       resp_hit;
    logic       resp_wb;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic [2:0] upd_index = '0;
    logic [1:0] upd_state = '0;
    logic       proto_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    msi_snoop_responder #(.IDX_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .snoop_valid (snoop_valid),
        .snoop_ready (snoop_ready),
        .snoop_cmd   (snoop_cmd),
        .snoop_index (snoop_index),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_index    (wb_index),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_wb     (resp_wb),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_index   (upd_index),
        .upd_state   (upd_state),
        .proto_err   (proto_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [2:0] idx, input logic [1:0] st);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_state = st;
        #1;
        check("upd_ready", upd_ready, 1);
        tick();
        upd_valid = 1'b0;
    endtask

    // Issues one snoop and follows it to its response. Optionally drives a
    // same-edge update (su_*) and an update probe in the first WB cycle (pr_*).
    task automatic snoop(input logic [1:0] cmd, input logic [2:0] idx, input int wb_wait,
                         input logic su_en, input logic [2:0] su_idx, input logic [1:0] su_st,
                         input logic pr_en, input logic [2:0] pr_idx,
                         output logic hit, output logic wbf, output logic err,
                         output int lat, output int wbcyc, output logic pr_rdy);
        int  c;
        logic done;
        snoop_valid = 1'b1;
        snoop_cmd   = cmd;
        snoop_index = idx;
        upd_valid   = su_en;
        upd_index   = su_idx;
        upd_state   = su_st;
        tick();
        snoop_valid = 1'b0;
        upd_valid   = 1'b0;
        c = 1; wbcyc = 0; err = 0; hit = 0; wbf = 0; lat = -1; pr_rdy = 1'b1; done = 0;
        while (!done && c < 60) begin
            upd_valid = 1'b0;
            if (proto_err) err = 1'b1;
            if (wb_valid) begin
                wbcyc++;
                check("wb_index", wb_index, idx);
                if (wbcyc == 1 && pr_en) begin
                    upd_valid = 1'b1;
                    upd_index = pr_idx;
                    upd_state = 2'b10;
                    #1;
                    pr_rdy = upd_ready;
                end
                wb_ready = (wbcyc > wb_wait);
            end
            if (resp_valid) begin
                hit  = resp_hit;
                wbf  = resp_wb;
                lat  = c;
                done = 1'b1;
            end
            tick();
            c++;
        end
        upd_valid = 1'b0;
        wb_ready  = 1'b0;
        if (!done) check("resp_timeout", 0, 1);
    endtask

    task automatic probe(input string tag, input logic [2:0] idx,
                         input logic exp_hit, input logic exp_wb);
        logic h, w, e, r;
        int   l, n;
        snoop(2'b10, idx, 0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, h, w, e, l, n, r);
        check({tag, "_hit"}, h, exp_hit);
        check({tag, "_wb"}, w, exp_wb);
    endtask

    initial begin
        logic h, w, e, r;
        int   l, n;

        rst = 1'b1;
        #12;
        check("rst_snoop_ready", snoop_ready, 1);
        check("rst_upd_ready", upd_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_proto_err", proto_err, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: M line read-missed -> writeback then SHARED
        do_upd(3'd3, 2'b01);
        snoop(2'b10, 3'd3, 0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, h, w, e, l, n, r);
        check("t1_hit", h, 1);
        check("t1_wb", w, 1);
        check("t1_err", e, 0);
        check("t1_lat", l, 3);
        check("t1_wbcyc", n, 1);
        probe("t1_idx3_S", 3'd3, 1'b1, 1'b0);

        // 2: S line write-missed -> INVALID, no writeback
        do_upd(3'd5, 2'b10);
        snoop(2'b01, 3'd5, 0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, h, w, e, l, n, r);
        check("t2_hit", h, 1);
        check("t2_wb", w, 0);
        check("t2_lat", l, 2);
        check("t2_wbcyc", n, 0);
        probe("t2_idx5_I", 3'd5, 1'b0, 1'b0);

        // 3: stalled writeback, same-index update blocked
        do_upd(3'd2, 2'b01);
        snoop(2'b01, 3'd2, 4, 1'b0, 3'd0, 2'd0, 1'b1, 3'd2, h, w, e, l, n, r);
        check("t3_hit", h, 1);
        check("t3_wb", w, 1);
        check("t3_wbcyc", n, 5);
        check("t3_lat", l, 7);
        check("t3_upd_stall", r, 0);
        probe("t3_idx2_I", 3'd2, 1'b0, 1'b0);

        // 4: protocol errors
        do_upd(3'd1, 2'b01);
        snoop(2'b00, 3'd1, 0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, h, w, e, l, n, r);
        check("t4_inv_err", e, 1);
        check("t4_inv_hit", h, 1);
        check("t4_inv_wb", w, 0);
        snoop(2'b11, 3'd1, 0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, h, w, e, l, n, r);
        check("t4_rsv_err", e, 1);
        check("t4_rsv_hit", h, 1);
        check("t4_rsv_lat", l, 2);
        do_upd(3'd1, 2'b11);
        check("t4_upd_err", proto_err, 1);
        tick();
        check("t4_upd_err_pulse", proto_err, 0);
        probe("t4_idx1_M", 3'd1, 1'b1, 1'b1);

        // 5: same-edge update seen by lookup; other-index update during WB
        snoop(2'b10, 3'd4, 0, 1'b1, 3'd4, 2'b01, 1'b1, 3'd6, h, w, e, l, n, r);
        check("t5_hit", h, 1);
        check("t5_wb", w, 1);
        check("t5_lat", l, 3);
        check("t5_upd6_rdy", r, 1);
        probe("t5_idx4_S", 3'd4, 1'b1, 1'b0);
        probe("t5_idx6_S", 3'd6, 1'b1, 1'b0);

        // 6: reset during WB
        do_upd(3'd7, 2'b01);
        do_upd(3'd0, 2'b10);
        snoop_valid = 1'b1;
        snoop_cmd   = 2'b10;
        snoop_index = 3'd7;
        tick();
        snoop_valid = 1'b0;
        tick();
        check("t6_wb_before", wb_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_wb_async", wb_valid, 0);
        check("t6_resp_async", resp_valid, 0);
        check("t6_ready_async", snoop_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t6_ready_after", snoop_ready, 1);
        probe("t6_idx7_I", 3'd7, 1'b0, 1'b0);
        probe("t6_idx0_I", 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

endmodule
